// File: rtl/trace_pipe.sv
// trace_pipe: shadows the CPU pipeline from decode to writeback and emits one trace record
// per retired instruction. Optional PC tracing is enabled by defining TRACE_PC_EN.
module trace_pipe #(
    parameter int DEPTH        = 3,
    parameter int FLUSH_STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instruction,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [11:0] id_imm,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_rd_value,
    output logic        trace_valid,
    output logic [31:0] trace_instruction,
    output logic [4:0]  trace_rd,
    output logic [4:0]  trace_rs1,
    output logic [4:0]  trace_rs2,
    output logic [11:0] trace_imm,
    output logic [31:0] trace_rd_value,
`ifdef TRACE_PC_EN
    input  logic [31:0] id_pc,
    output logic [31:0] trace_pc,
`endif
    output logic [31:0] retire_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
`ifdef TRACE_PC_EN
        logic [31:0] pc;
`endif
    } entry_t;

    entry_t      pipe_q [DEPTH];
    entry_t      pipe_d [DEPTH];
    entry_t      id_entry;
    entry_t      wb;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        retire;

    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_valid & ~flush;
        id_entry.instr = id_instruction;
        id_entry.rd    = id_rd;
        id_entry.rs1   = id_rs1;
        id_entry.rs2   = id_rs2;
        id_entry.imm   = id_imm;
`ifdef TRACE_PC_EN
        id_entry.pc    = id_pc;
`endif
    end

    // Advance or hold first, then flush kills the youngest stages regardless of stall.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (!stall) begin
            pipe_d[0] = id_entry;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < FLUSH_STAGES; i++) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    assign wb      = pipe_q[DEPTH-1];
    assign retire  = wb.valid & ~stall & ~rst;
    assign count_d = retire ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            count_q <= count_d;
        end
    end

    assign trace_valid       = retire;
    assign trace_instruction = wb.valid ? wb.instr : 32'd0;
    assign trace_rd          = wb.valid ? wb.rd    : 5'd0;
    assign trace_rs1         = wb.valid ? wb.rs1   : 5'd0;
    assign trace_rs2         = wb.valid ? wb.rs2   : 5'd0;
    assign trace_imm         = wb.valid ? wb.imm   : 12'd0;
    // Writeback value is live from the register-file port; x0 writes are never reported.
    assign trace_rd_value    = (wb.valid && wb_reg_write && (wb.rd != 5'd0)) ? wb_rd_value : 32'd0;
`ifdef TRACE_PC_EN
    assign trace_pc          = wb.valid ? wb.pc : 32'd0;
`endif
    assign retire_count      = count_q;

endmodule

// File: tb/tb_trace_pipe.sv
// Testbench for trace_pipe: directed scenarios plus random traffic, checked by a queue-based
// reference model feeding a scoreboard that a negedge monitor drains.
module tb_trace_pipe;

    localparam int DEPTH = 3;
    localparam int FLUSH_STAGES = 1;
    localparam int W = 32 + 5 + 5 + 5 + 12 + 32 + 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [11:0] id_imm;
    logic        stall, flush, wb_reg_write;
    logic [31:0] wb_rd_value;
    logic [31:0] id_pc;
    logic        trace_valid;
    logic [31:0] trace_instruction;
    logic [4:0]  trace_rd, trace_rs1, trace_rs2;
    logic [11:0] trace_imm;
    logic [31:0] trace_rd_value;
    logic [31:0] retire_count;
    logic [31:0] pc_act;

    trace_pipe #(.DEPTH(DEPTH), .FLUSH_STAGES(FLUSH_STAGES)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
        .stall(stall), .flush(flush), .wb_reg_write(wb_reg_write), .wb_rd_value(wb_rd_value),
        .trace_valid(trace_valid), .trace_instruction(trace_instruction),
        .trace_rd(trace_rd), .trace_rs1(trace_rs1), .trace_rs2(trace_rs2),
        .trace_imm(trace_imm), .trace_rd_value(trace_rd_value),
`ifdef TRACE_PC_EN
        .id_pc(id_pc), .trace_pc(pc_act),
`endif
        .retire_count(retire_count)
    );

`ifndef TRACE_PC_EN
    assign pc_act = 32'd0;
`endif

    always #5 clk = ~clk;

    // Reference model: in-flight instructions with their age in stages.
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] pc;
        int          age;
    } rec_t;

    rec_t         inflight[$];
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_count = 0;
    logic [31:0]  exp_count = 0;
    logic         exp_valid_now = 1'b0;
    logic         exp_wb_occ = 1'b0;
    logic         mon_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic model_eval();
        int    idx;
        rec_t  r;
        logic [31:0] rdv;
        idx = -1;
        foreach (inflight[i]) if (inflight[i].age == DEPTH - 1) idx = i;
        exp_wb_occ    = (idx >= 0);
        exp_valid_now = (idx >= 0) && !stall && !rst;
        if (exp_valid_now) begin
            r   = inflight[idx];
            rdv = (wb_reg_write && r.rd != 5'd0) ? wb_rd_value : 32'd0;
            exp_q.push_back({r.instr, r.rd, r.rs1, r.rs2, r.imm, rdv, r.pc});
        end
        if (rst) begin
            inflight.delete();
            m_count = 0;
        end else begin
            if (exp_valid_now) m_count = m_count + 32'd1;
            if (!stall) begin
                if (idx >= 0) inflight.delete(idx);
                foreach (inflight[i]) inflight[i].age++;
                if (id_valid && !flush) begin
                    r.instr = id_instruction; r.rd = id_rd; r.rs1 = id_rs1; r.rs2 = id_rs2;
                    r.imm = id_imm; r.age = 0;
`ifdef TRACE_PC_EN
                    r.pc = id_pc;
`else
                    r.pc = 32'd0;
`endif
                    inflight.push_back(r);
                end
            end
            if (flush) begin
                for (int i = inflight.size() - 1; i >= 0; i--)
                    if (inflight[i].age < FLUSH_STAGES) inflight.delete(i);
            end
        end
    endtask

    // Inputs are already set for this cycle; evaluate the model, then cross the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        exp_count = m_count;
    endtask

    task automatic set_idle();
        rst = 1'b0; id_valid = 1'b0; id_instruction = '0; id_rd = '0; id_rs1 = '0;
        id_rs2 = '0; id_imm = '0; id_pc = '0; stall = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd_value = '0;
    endtask

    task automatic drive_instr(input logic [31:0] ins, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [11:0] imm);
        id_valid = 1'b1; id_instruction = ins; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_imm = imm; id_pc = $urandom;
    endtask

    task automatic drive_random();
        drive_instr($urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 12'($urandom));
        id_valid = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        logic [W-1:0] got, want;
        if (mon_en) begin
            got = {trace_instruction, trace_rd, trace_rs1, trace_rs2, trace_imm, trace_rd_value, pc_act};
            n_checks++;
            if (trace_valid !== exp_valid_now) begin
                n_fail++;
                $display("FAIL valid t=%0t got=%b want=%b", $time, trace_valid, exp_valid_now);
            end
            n_checks++;
            if (retire_count !== exp_count) begin
                n_fail++;
                $display("FAIL count t=%0t got=%0d want=%0d", $time, retire_count, exp_count);
            end
            if (trace_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL record t=%0t unexpected record got=%h", $time, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL record t=%0t got=%h want=%h", $time, got, want);
                    end
                end
            end else if (!exp_wb_occ) begin
                n_checks++;
                if (got !== '0) begin
                    n_fail++;
                    $display("FAIL idle_zero t=%0t got=%h want=0", $time, got);
                end
            end
        end
    end

    initial begin
        set_idle();
        // Reset for two cycles while decode claims valid instructions.
        rst = 1'b1;
        drive_instr(32'h00700293, 5'd5, 5'd0, 5'd7, 12'd7);
        @(posedge clk);
        #1;
        exp_count = 0;
        mon_en = 1'b1;
        tick();
        set_idle();

        // addi x5,x0,7 followed by its writeback.
        drive_instr(32'h00700293, 5'd5, 5'd0, 5'd7, 12'd7);
        wb_reg_write = 1'b1; wb_rd_value = 32'd7;
        tick();
        id_valid = 1'b0;
        repeat (DEPTH) tick();

        // Four back-to-back instructions.
        for (int i = 0; i < 4; i++) begin
            drive_instr(32'h00100093 + (i << 20), 5'(i + 1), 5'd0, 5'(i), 12'(i + 1));
            wb_rd_value = 32'h100 + i;
            tick();
        end
        id_valid = 1'b0;
        repeat (DEPTH + 1) tick();

        // Writeback entry held by a two-cycle stall.
        drive_instr(32'h00a00513, 5'd10, 5'd0, 5'd10, 12'd10);
        wb_rd_value = 32'hcafe;
        tick();
        id_valid = 1'b0;
        repeat (DEPTH - 1) tick();
        stall = 1'b1;
        repeat (2) tick();
        stall = 1'b0;
        repeat (2) tick();

        // Branch in stage 1, younger in stage 0, flush with a valid decode input.
        drive_instr(32'h00208463, 5'd8, 5'd1, 5'd2, 12'd8);
        tick();
        drive_instr(32'h00300193, 5'd3, 5'd0, 5'd3, 12'd3);
        tick();
        drive_instr(32'h00400213, 5'd4, 5'd0, 5'd4, 12'd4);
        flush = 1'b1;
        tick();
        set_idle();
        wb_reg_write = 1'b1; wb_rd_value = 32'h55;
        repeat (DEPTH + 1) tick();

        // Store with no register write, then an x0 destination.
        drive_instr(32'h00512223, 5'd4, 5'd2, 5'd5, 12'd4);
        wb_reg_write = 1'b0; wb_rd_value = 32'hdead;
        tick();
        drive_instr(32'h00000013, 5'd0, 5'd0, 5'd0, 12'd0);
        tick();
        id_valid = 1'b0;
        tick();
        wb_reg_write = 1'b1; wb_rd_value = 32'h1234;
        repeat (DEPTH) tick();

        // Mid-operation reset discards in-flight entries.
        drive_instr(32'h11111111, 5'd1, 5'd2, 5'd3, 12'h111);
        tick();
        drive_instr(32'h22222222, 5'd2, 5'd3, 5'd4, 12'h222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_instr(32'h33333333, 5'd3, 5'd4, 5'd5, 12'h333);
        tick();
        id_valid = 1'b0;
        repeat (DEPTH + 1) tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            drive_random();
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            wb_reg_write = $urandom_range(0, 1);
            wb_rd_value  = $urandom;
            tick();
        end

        set_idle();
        repeat (DEPTH + 2) tick();
        mon_en = 1'b0;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain leftover=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
